// File: rtl/vx_writeback_arb.sv
// Two-source (ALU/MEM) writeback arbiter with round-robin tie-break and a registered
// one-hot register-file write port. Define VX_WB_PERF_COUNT_EN to enable the stall counter.
module vx_writeback_arb #(
  parameter  int NUM_WARPS = 8,
  localparam int NW_BITS   = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [NW_BITS-1:0]   alu_warp,
  input  logic                 alu_wb,
  input  logic [4:0]           alu_rd,
  input  logic [31:0]          alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [NW_BITS-1:0]   mem_warp,
  input  logic                 mem_wb,
  input  logic [4:0]           mem_rd,
  input  logic [31:0]          mem_data,
  output logic                 out_valid,
  output logic [NUM_WARPS-1:0] out_wb_warp,
  output logic [4:0]           out_rd,
  output logic [31:0]          out_data,
  output logic [31:0]          out_stall_count
);

  typedef struct packed {
    logic [NW_BITS-1:0] warp;
    logic               wb;
    logic [4:0]         rd;
    logic [31:0]        data;
  } wb_req_t;

  wb_req_t              alu_req, mem_req, sel_req;
  logic                 rr;
  logic                 grant_alu, grant_mem, do_write;
  logic [NUM_WARPS-1:0] warp_dec;

  assign alu_req = '{warp: alu_warp, wb: alu_wb, rd: alu_rd, data: alu_data};
  assign mem_req = '{warp: mem_warp, wb: mem_wb, rd: mem_rd, data: mem_data};

  // rr only matters on a tie; nothing is granted while in reset.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (reset) begin
      if (alu_valid && (!mem_valid || !rr)) grant_alu = 1'b1;
      else if (mem_valid)                   grant_mem = 1'b1;
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign sel_req   = grant_mem ? mem_req : alu_req;
  assign do_write  = (grant_alu || grant_mem) && sel_req.wb && (sel_req.rd != 5'd0);

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_dec
    assign warp_dec[w] = (sel_req.warp == NW_BITS'(w));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_wb_warp <= '0;
      out_rd      <= '0;
      out_data    <= '0;
      rr          <= 1'b0;
    end else begin
      out_valid   <= do_write;
      out_wb_warp <= do_write ? warp_dec : '0;
      if (do_write) begin
        out_rd   <= sel_req.rd;
        out_data <= sel_req.data;
      end
      if (grant_alu || grant_mem) rr <= grant_alu;
    end
  end

`ifdef VX_WB_PERF_COUNT_EN
  logic [31:0] stall_cnt;
  logic        stall;

  // Only one source can be refused per cycle, so the count advances by at most one.
  assign stall = (alu_valid && !grant_alu) || (mem_valid && !grant_mem);

  always_ff @(posedge clk) begin
    if (!reset)     stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end

  assign out_stall_count = stall_cnt;
`else
  assign out_stall_count = '0;
`endif

endmodule

// File: doc/vx_writeback_arb.md
VX_WRITEBACK_ARB -- requirements
Module: VX_writeback_arb

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8, number of warps (power of 2, >=2); NW_BITS = log2(NUM_WARPS).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports alu_valid / mem_valid  input  1  source holds a writeback request.
REQ-005 SHALL have ports alu_ready / mem_ready  output  1  source request accepted this cycle (combinational).
REQ-006 SHALL have ports alu_warp / mem_warp  input  NW_BITS  warp number of the request.
REQ-007 SHALL have ports alu_wb / mem_wb  input  1  request writes a register.
REQ-008 SHALL have ports alu_rd / mem_rd  input  5  destination register.
REQ-009 SHALL have ports alu_data / mem_data  input  32  write data.
REQ-010 SHALL have port out_valid  output  1  registered writeback valid to the register files.
REQ-011 SHALL have port out_wb_warp  output  NUM_WARPS  registered one-hot warp select (bit w drives warp w's register-file in_wb_warp).
REQ-012 SHALL have ports out_rd (5), out_data (32)  output  registered destination and data.
REQ-013 SHALL have port out_stall_count  output  32  cycles a valid source was refused.

Function
REQ-014 SHALL accept at most one request per cycle; handshake completes when valid && ready on the same edge.
REQ-015 SHALL, with one source valid, assert that source's ready and deassert the other.
REQ-016 SHALL, with both valid, grant the source selected by 1-bit round-robin pointer rr (0 = ALU, 1 = MEM).
REQ-017 SHALL update rr after every grant to point at the non-granted source; SHALL hold rr in idle cycles.
REQ-018 SHALL register the granted request into out_* with exactly 1 cycle latency; out_valid high for exactly one cycle per write.
REQ-019 SHALL drop (accept, ready high, but out_valid low next cycle) requests with wb=0 or rd=0.
REQ-020 SHALL set out_wb_warp = one-hot(warp) when out_valid=1, else all zeros.
REQ-021 SHALL hold out_rd/out_data at last values when out_valid=0.
REQ-022 SHALL keep ready signals independent of downstream state (register files always accept).
REQ-023 SHALL treat a valid source refused by arbitration as holding its request; no internal buffering.

Reset
REQ-024 SHALL, while reset=0 at a rising edge: out_valid=0, out_wb_warp=0, out_rd=0, out_data=0, rr=0, out_stall_count=0.
REQ-025 SHALL drive alu_ready=mem_ready=0 while reset=0; requests present during reset are not accepted.
REQ-026 SHALL, on reset mid-operation, discard any pending out_valid; first post-reset grant with both valid goes to ALU.

Configuration
REQ-027 SHALL, with macro VX_WB_PERF_COUNT_EN defined, increment out_stall_count (wrapping at 2^32) each cycle where a valid source has ready=0, +2 is impossible (max +1 per cycle).
REQ-028 SHALL, without VX_WB_PERF_COUNT_EN, tie out_stall_count to 0 and implement no counter logic.

Verification
REQ-029 SHALL cover: alu_valid only, warp=3, rd=5, data=0xDEADBEEF -> alu_ready=1; next cycle out_valid=1, out_wb_warp=0x08, out_rd=5, out_data=0xDEADBEEF.
REQ-030 SHALL cover: both valid for 4 consecutive cycles after reset -> grants ALU, MEM, ALU, MEM; out_stall_count=4 with macro, 0 without.
REQ-031 SHALL cover: mem_valid, wb=1, rd=0 -> mem_ready=1; next cycle out_valid=0, out_wb_warp=0.
REQ-032 SHALL cover: alu_valid, wb=0, rd=7 -> accepted, no output write; rr then points at MEM.
REQ-033 SHALL cover: reset=0 asserted cycle after a grant -> out_valid=0 next edge; after release, both valid -> ALU granted first.
REQ-034 SHALL cover: counter preloaded via force to 0xFFFFFFFF, one stall cycle -> out_stall_count=0.
